stopwatch_ctrl: RTL
===================

Name: stopwatch_ctrl

Overview:
Control FSM for the stopwatch: accepts debounced start/stop, lap and clear command pulses and sequences the base timer through its enable and reset inputs. It counts rising edges of the timer's toggling base_tick into a BCD mm:ss.cc time value and provides the display value, including a frozen lap snapshot. It sits between the button front-end and the timer/display logic.

Parameters:
TICK_DIV, 1, number of base_tick rising edges per hundredth-of-second increment (1..255)
MIN_MAX, 59, highest minutes value; the count wraps after MIN_MAX:59.99

Ports:
sys_clk  in  1  system clock; all logic on rising edge
reset_n  in  1  synchronous reset, active-high (1 = reset)
start_stop  in  1  one-cycle command pulse
lap  in  1  one-cycle command pulse
clear  in  1  one-cycle command pulse
base_tick  in  1  toggling tick from the timer
timer_enb  out  1  enable to the timer
timer_rst_n  out  1  active-low clear to the timer
disp_cs  out  8  BCD hundredths {tens,units}
disp_sec  out  8  BCD seconds
disp_min  out  8  BCD minutes
running  out  1  1 in RUN or LAP
lap_active  out  1  1 in LAP (display frozen)
overflow  out  1  sticky wrap flag

Behaviour:
- Reset (reset_n=1 at a clock edge) sets the following:
  - state=IDLE.
  - Count, lap snapshot and the divider counter are 0.
  - bt_q=0.
  - timer_enb=0, timer_rst_n=0, overflow=0.
  - All disp outputs read 00.
- timer_rst_n returns to 1 on the first edge after reset deasserts.
- States: IDLE, RUN, LAP, PAUSE. Command priority when pulses coincide is clear > start_stop > lap; only one command acts per cycle.
- Transitions:
  - IDLE + start_stop -> RUN.
  - IDLE + clear -> IDLE, with a timer clear pulse.
  - IDLE + lap is ignored.
  - RUN + start_stop -> PAUSE.
  - RUN + lap -> LAP; the snapshot captures the current (pre-update) count registers.
  - RUN + clear is ignored.
  - LAP + lap -> RUN (display live again).
  - LAP + start_stop -> PAUSE; the freeze is released and the display shows the live count.
  - LAP + clear is ignored.
  - PAUSE + start_stop -> RUN.
  - PAUSE + clear -> IDLE; count, snapshot, divider and overflow are zeroed.
  - PAUSE + lap is ignored.
- timer_enb is registered from the next state: it is 1 exactly when the registered state is RUN or LAP, so it rises one clock after the start_stop edge.
- timer_rst_n is driven 0 for exactly one clock following any honoured clear, then returns to 1.
- Tick detect:
  - bt_q samples base_tick every cycle in all states.
  - tick_evt = base_tick & ~bt_q, and is acted on only when the current state is RUN or LAP.
  - A tick in the cycle that leaves RUN/LAP is counted. A tick in the cycle IDLE/PAUSE -> RUN is not counted.
- Counting on tick_evt:
  - The divider increments.
  - When the divider equals TICK_DIV-1, it resets to 0 and cs advances.
  - cs wraps 99 -> 00 and carries into sec.
  - sec wraps 59 -> 00 and carries into min.
  - At MIN_MAX:59.99 the next advance gives 00:00.00 and sets overflow=1. overflow is sticky until clear or reset.
- BCD digits never hold values above 9. Each digit increments and carries independently.
- Display mapping:
  - disp_* = snapshot while in LAP, otherwise the live count (combinational mux of registers).
  - A counted tick is visible on disp_* one clock after the edge that saw tick_evt.
- Flags: running=1 in RUN or LAP; lap_active=1 in LAP only; both are decoded from the registered state.
- reset_n asserted mid-count overrides all commands and ticks in that cycle.

Test Plan:
- Reset, then start_stop; toggle base_tick with 100 rising edges (TICK_DIV=1) -> timer_enb=1 one clock after start_stop; disp reads 00:01.00; running=1.
- Run to 00:00.37, pulse lap, feed 20 more ticks -> disp holds 00:00.37 with lap_active=1; pulse lap again -> disp 00:00.57.
- Run, pulse start_stop (PAUSE), feed 10 ticks -> count unchanged, timer_enb=0; then pulse clear -> disp 00:00.00, timer_rst_n=0 for exactly one clock, state IDLE.
- Pulse clear during RUN -> ignored: count continues and timer_rst_n stays 1. Pulse clear+start_stop in the same cycle in PAUSE -> only clear acts, state IDLE.
- Preload to 59:59.99 (MIN_MAX=59), one tick -> disp 00:00.00, overflow=1; overflow stays 1 until clear.
- TICK_DIV=4: 7 ticks -> disp_cs=01. Assert reset_n mid-run -> all outputs at reset values on the next edge, with timer_rst_n=0.

Source files
------------

// File: rtl/stopwatch_ctrl_if.sv
// Command, tick and display bundle between the button front-end, the stopwatch
// controller and the timer/display logic.
interface stopwatch_ctrl_if;
  logic       start_stop;
  logic       lap;
  logic       clear;
  logic       base_tick;
  logic       timer_enb;
  logic       timer_rst_n;
  logic [7:0] disp_cs;
  logic [7:0] disp_sec;
  logic [7:0] disp_min;
  logic       running;
  logic       lap_active;
  logic       overflow;

  modport master (
    output start_stop, lap, clear, base_tick,
    input  timer_enb, timer_rst_n, disp_cs, disp_sec, disp_min,
           running, lap_active, overflow
  );

  modport slave (
    input  start_stop, lap, clear, base_tick,
    output timer_enb, timer_rst_n, disp_cs, disp_sec, disp_min,
           running, lap_active, overflow
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM: sequences the base timer, counts base_tick rising edges
// into a BCD mm:ss.cc value and drives the live or lap-frozen display.
module stopwatch_ctrl #(
  parameter int TICK_DIV = 1,
  parameter int MIN_MAX  = 59
) (
  input  logic               sys_clk,
  input  logic               reset_n,
  stopwatch_ctrl_if.slave    sw
);

  typedef enum logic [1:0] {IDLE, RUN, LAP, PAUSE} state_t;

  localparam logic [7:0] DIV_LAST = 8'(TICK_DIV - 1);
  localparam logic [3:0] MIN_T    = 4'(MIN_MAX / 10);
  localparam logic [3:0] MIN_U    = 4'(MIN_MAX % 10);

  state_t      state_q, state_d;
  logic        clear_hit, snap_take;
  logic        bt_q;
  logic        tick_evt;
  logic        counting;
  logic [7:0]  div_q;
  logic [23:0] cnt_q;
  logic [23:0] snap_q;
  logic [24:0] cnt_adv;
  logic        timer_enb_q, timer_rst_n_q, overflow_q;

  // Advance {min_t,min_u,sec_t,sec_u,cs_t,cs_u} by one hundredth; bit 24 flags the wrap.
  function automatic logic [24:0] time_advance(input logic [23:0] t);
    logic [3:0] mt, mu, st, su, ct, cu;
    logic       wrap;
    {mt, mu, st, su, ct, cu} = t;
    wrap = 1'b0;
    if (cu != 4'd9) cu = cu + 4'd1;
    else begin
      cu = 4'd0;
      if (ct != 4'd9) ct = ct + 4'd1;
      else begin
        ct = 4'd0;
        if (su != 4'd9) su = su + 4'd1;
        else begin
          su = 4'd0;
          if (st != 4'd5) st = st + 4'd1;
          else begin
            st = 4'd0;
            if (mt == MIN_T && mu == MIN_U) begin
              mt = 4'd0;
              mu = 4'd0;
              wrap = 1'b1;
            end else if (mu != 4'd9) mu = mu + 4'd1;
            else begin
              mu = 4'd0;
              mt = mt + 4'd1;
            end
          end
        end
      end
    end
    return {wrap, mt, mu, st, su, ct, cu};
  endfunction

  // Command decode: clear > start_stop > lap, ignored commands do not block lower ones.
  always_comb begin
    state_d   = state_q;
    clear_hit = 1'b0;
    snap_take = 1'b0;
    case (state_q)
      IDLE: begin
        if (sw.clear) clear_hit = 1'b1;
        else if (sw.start_stop) state_d = RUN;
      end
      RUN: begin
        if (sw.start_stop) state_d = PAUSE;
        else if (sw.lap) begin
          state_d   = LAP;
          snap_take = 1'b1;
        end
      end
      LAP: begin
        if (sw.start_stop) state_d = PAUSE;
        else if (sw.lap) state_d = RUN;
      end
      PAUSE: begin
        if (sw.clear) begin
          clear_hit = 1'b1;
          state_d   = IDLE;
        end else if (sw.start_stop) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  assign counting = (state_q == RUN) || (state_q == LAP);
  assign tick_evt = sw.base_tick & ~bt_q;
  assign cnt_adv  = time_advance(cnt_q);

  // Registered control: state, timer handshake, tick edge history
  always_ff @(posedge sys_clk) begin
    if (reset_n) begin
      state_q       <= IDLE;
      bt_q          <= 1'b0;
      timer_enb_q   <= 1'b0;
      timer_rst_n_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      bt_q          <= sw.base_tick;
      timer_enb_q   <= (state_d == RUN) || (state_d == LAP);
      timer_rst_n_q <= ~clear_hit;
    end
  end

  // Registered count, divider, lap snapshot and sticky wrap flag
  always_ff @(posedge sys_clk) begin
    if (reset_n || clear_hit) begin
      div_q      <= 8'd0;
      cnt_q      <= 24'd0;
      snap_q     <= 24'd0;
      overflow_q <= 1'b0;
    end else begin
      if (snap_take) snap_q <= cnt_q;
      if (counting && tick_evt) begin
        if (div_q == DIV_LAST) begin
          div_q <= 8'd0;
          cnt_q <= cnt_adv[23:0];
          if (cnt_adv[24]) overflow_q <= 1'b1;
        end else begin
          div_q <= div_q + 8'd1;
        end
      end
    end
  end

  assign sw.timer_enb   = timer_enb_q;
  assign sw.timer_rst_n = timer_rst_n_q;
  assign sw.overflow    = overflow_q;
  assign sw.running     = counting;
  assign sw.lap_active  = (state_q == LAP);
  assign {sw.disp_min, sw.disp_sec, sw.disp_cs} = (state_q == LAP) ? snap_q : cnt_q;

endmodule
